// File: rtl/stream_scrambler_pipe_if.sv
// Valid/ready pixel stream with a start-of-frame marker.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface stream_scrambler_pipe_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              sof;

  modport master (output valid, output data, output sof, input ready);
  modport slave  (input valid, input data, input sof, output ready);
endinterface

// File: rtl/stream_scrambler_pipe.sv
// Pixel stream scrambler/descrambler with a single output register.
// The keystream comes from a Galois LFSR that restarts from SEED^key at each start of frame.
// Key, mode and direction are double-buffered. A key_load only fills the shadow registers.
// The shadow values reach the datapath only when an SOF beat is accepted.
module stream_scrambler_pipe #(
  parameter int                DATA_W = 16,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = 'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_dir,
  input  logic [LFSR_W-1:0]    key_in,
  input  logic                 key_load,
  stream_scrambler_pipe_if.slave  in_s,
  stream_scrambler_pipe_if.master out_m,
  output logic [15:0]          frame_cnt,
  output logic                 lockup_err
);

  localparam int RW = $clog2(DATA_W);

  logic [LFSR_W-1:0] sh_key_q, sh_key_d;
  logic [1:0]        sh_mode_q, sh_mode_d;
  logic              sh_dir_q, sh_dir_d;
  logic [1:0]        act_mode_q, act_mode_d;
  logic              act_dir_q, act_dir_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sof_q, out_sof_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              lockup_q, lockup_d;

  logic              accept;
  logic              sof_acc;
  logic [LFSR_W-1:0] eff_key;
  logic [1:0]        eff_mode;
  logic              eff_dir;
  logic [1:0]        use_mode;
  logic              use_dir;
  logic [LFSR_W-1:0] seed_mix;
  logic [LFSR_W-1:0] ks;
  logic [LFSR_W-1:0] stepped;
  logic [DATA_W-1:0] kword;
  logic [RW-1:0]     rot;
  logic [DATA_W-1:0] mixed;
  logic [DATA_W-1:0] result;

  assign in_s.ready  = !out_valid_q | out_m.ready;
  assign accept      = in_s.valid & in_s.ready;
  assign sof_acc     = accept & in_s.sof;

  assign out_m.valid = out_valid_q;
  assign out_m.data  = out_data_q;
  assign out_m.sof   = out_sof_q;
  assign frame_cnt   = frame_cnt_q;
  assign lockup_err  = lockup_q;

  // A key_load in the same cycle as an SOF accept takes effect on that frame.
  // Reserved mode 3 falls into the plain-XOR arm of the case statement.
  always_comb begin
    eff_key  = key_load ? key_in   : sh_key_q;
    eff_mode = key_load ? cfg_mode : sh_mode_q;
    eff_dir  = key_load ? cfg_dir  : sh_dir_q;
    use_mode = in_s.sof ? eff_mode : act_mode_q;
    use_dir  = in_s.sof ? eff_dir  : act_dir_q;
    seed_mix = SEED ^ eff_key;
    if (in_s.sof) begin
      ks = (seed_mix == '0) ? SEED : seed_mix;
    end else begin
      ks = lfsr_q;
    end
    stepped = ks[0] ? ((ks >> 1) ^ POLY) : (ks >> 1);
    kword = '0;
    for (int i = 0; i < DATA_W; i++) begin
      kword[i] = ks[i % LFSR_W];
    end
    rot   = kword[RW-1:0];
    mixed = in_s.data ^ kword;
    case (use_mode)
      2'd0:    result = in_s.data;
      2'd2: begin
        if (use_dir) begin
          result = ((in_s.data << rot) | (in_s.data >> (DATA_W - int'(rot)))) ^ kword;
        end else begin
          result = (mixed >> rot) | (mixed << (DATA_W - int'(rot)));
        end
      end
      default: result = mixed;
    endcase
  end

  // Next-state computation for the config registers, the LFSR and the output register.
  // The LFSR advances only on an accepted beat, so it holds while the output is stalled.
  always_comb begin
    sh_key_d    = sh_key_q;
    sh_mode_d   = sh_mode_q;
    sh_dir_d    = sh_dir_q;
    act_mode_d  = act_mode_q;
    act_dir_d   = act_dir_q;
    lfsr_d      = lfsr_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    lockup_d    = lockup_q;
    if (key_load) begin
      sh_key_d  = key_in;
      sh_mode_d = cfg_mode;
      sh_dir_d  = cfg_dir;
    end
    if (accept) begin
      out_data_d  = result;
      out_sof_d   = in_s.sof;
      out_valid_d = 1'b1;
      if (stepped == '0) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = stepped;
      end
      if (sof_acc) begin
        act_mode_d  = eff_mode;
        act_dir_d   = eff_dir;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end else if (out_m.ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Register update with synchronous reset. A reset drops any beat still held in the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_key_q    <= '0;
      sh_mode_q   <= 2'd0;
      sh_dir_q    <= 1'b1;
      act_mode_q  <= 2'd0;
      act_dir_q   <= 1'b1;
      lfsr_q      <= SEED;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= 16'd0;
      lockup_q    <= 1'b0;
    end else begin
      sh_key_q    <= sh_key_d;
      sh_mode_q   <= sh_mode_d;
      sh_dir_q    <= sh_dir_d;
      act_mode_q  <= act_mode_d;
      act_dir_q   <= act_dir_d;
      lfsr_q      <= lfsr_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
      lockup_q    <= lockup_d;
    end
  end

endmodule
